// File: rtl/codec_cfg_pkg.sv
// rtl/codec_cfg_pkg.sv - shared constants, state encoding and helpers for the codec configuration sequencer
package codec_cfg_pkg;

    // Codec register addresses (7-bit register field of each I2C write)
    localparam logic [6:0] REG_LEFT_IN  = 7'h00;
    localparam logic [6:0] REG_RIGHT_IN = 7'h01;
    localparam logic [6:0] REG_LEFT_HP  = 7'h02;
    localparam logic [6:0] REG_RIGHT_HP = 7'h03;
    localparam logic [6:0] REG_ANA_PATH = 7'h04;
    localparam logic [6:0] REG_DIG_PATH = 7'h05;
    localparam logic [6:0] REG_PWR_DOWN = 7'h06;
    localparam logic [6:0] REG_DIG_IF   = 7'h07;
    localparam logic [6:0] REG_SAMPLING = 7'h08;
    localparam logic [6:0] REG_ACTIVE   = 7'h09;
    localparam logic [6:0] REG_RESET    = 7'h0F;

    // Error codes: controller reports 1..5 as failures and F as a pass flag;
    // E is reserved for the sequencer's own timeout.
    localparam logic [3:0] ERR_TIMEOUT = 4'hE;
    localparam logic [3:0] ERR_PASS    = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RST,
        ST_WAIT,
        ST_RETRY,
        ST_GAP,
        ST_DONE,
        ST_FAIL
    } state_t;

    function automatic logic is_fail_code(input logic [3:0] code);
        return (code >= 4'd1) && (code <= 4'd5);
    endfunction

endpackage

// File: rtl/codec_cfg_sequencer_if.sv
// rtl/codec_cfg_sequencer_if.sv - bus between the configuration sequencer and the I2C write controller
// master: sequencer side (drives reset/enable, address, register, data, rw; reads done, error)
// slave : controller side
interface codec_cfg_sequencer_if;
    logic       i2c_rst_n;
    logic [6:0] i2c_address;
    logic [6:0] i2c_register;
    logic [8:0] i2c_data;
    logic       i2c_rw;
    logic       i2c_done;
    logic [3:0] i2c_error;

    modport master (
        output i2c_rst_n,
        output i2c_address,
        output i2c_register,
        output i2c_data,
        output i2c_rw,
        input  i2c_done,
        input  i2c_error
    );

    modport slave (
        input  i2c_rst_n,
        input  i2c_address,
        input  i2c_register,
        input  i2c_data,
        input  i2c_rw,
        output i2c_done,
        output i2c_error
    );
endinterface

// File: rtl/codec_cfg_rom.sv
// rtl/codec_cfg_rom.sv - combinational codec configuration table, index -> {register, data}
// idx      in  4  table entry
// reg_addr out 7  register field (0 when idx >= NUM_REGS)
// reg_data out 9  data field     (0 when idx >= NUM_REGS)
module codec_cfg_rom
    import codec_cfg_pkg::*;
#(
    parameter int NUM_REGS = 10
) (
    input  logic [3:0] idx,
    output logic [6:0] reg_addr,
    output logic [8:0] reg_data
);

    localparam logic [3:0] LAST_IDX   = 4'(NUM_REGS - 1);
    localparam logic [4:0] NUM_REGS_W = 5'(NUM_REGS);

    // First entry always resets the codec, last entry always activates it;
    // the entries in between are taken in order from the setup list.
    always_comb begin
        reg_addr = '0;
        reg_data = '0;
        if ({1'b0, idx} < NUM_REGS_W) begin
            if (idx == 4'd0) begin
                reg_addr = REG_RESET;
                reg_data = 9'h000;
            end else if (idx == LAST_IDX) begin
                reg_addr = REG_ACTIVE;
                reg_data = 9'h001;
            end else begin
                case (idx)
                    4'd1:    begin reg_addr = REG_PWR_DOWN; reg_data = 9'h002; end
                    4'd2:    begin reg_addr = REG_LEFT_HP;  reg_data = 9'h079; end
                    4'd3:    begin reg_addr = REG_RIGHT_HP; reg_data = 9'h079; end
                    4'd4:    begin reg_addr = REG_ANA_PATH; reg_data = 9'h012; end
                    4'd5:    begin reg_addr = REG_DIG_PATH; reg_data = 9'h006; end
                    4'd6:    begin reg_addr = REG_DIG_IF;   reg_data = 9'h042; end
                    4'd7:    begin reg_addr = REG_SAMPLING; reg_data = 9'h000; end
                    4'd8:    begin reg_addr = REG_LEFT_IN;  reg_data = 9'h017; end
                    default: begin reg_addr = REG_RIGHT_IN; reg_data = 9'h017; end
                endcase
            end
        end
    end

endmodule

// File: rtl/codec_cfg_sequencer.sv
// rtl/codec_cfg_sequencer.sv - steps the codec configuration table through the I2C write controller
// clk        in  1  system clock
// rst        in  1  asynchronous active-low reset
// start      in  1  pulse, (re)starts the sequence from entry 0 when not busy
// i2c        master modport: controller reset/enable, address, register, data, rw, done, error
// busy       out 1  sequence in progress
// cfg_done   out 1  all entries written
// cfg_error  out 1  sequence aborted
// fail_index out 4  entry index at abort
// fail_code  out 4  error code at abort (E = timeout)
module codec_cfg_sequencer
    import codec_cfg_pkg::*;
#(
    parameter int         NUM_REGS       = 10,
    parameter logic [6:0] DEV_ADDR       = 7'h1A,
    parameter int         RST_HOLD       = 8,
    parameter int         GAP_CYCLES     = 1024,
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter int         MAX_RETRY      = 3,
    parameter bit         AUTO_START     = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    codec_cfg_sequencer_if.master  i2c,
    output logic                   busy,
    output logic                   cfg_done,
    output logic                   cfg_error,
    output logic [3:0]             fail_index,
    output logic [3:0]             fail_code
);

    localparam logic [3:0]  LAST_IDX  = 4'(NUM_REGS - 1);
    localparam logic [10:0] HOLD_LAST = 11'(RST_HOLD - 1);
    localparam logic [10:0] GAP_LAST  = 11'(GAP_CYCLES - 1);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  RETRY_MAX = 2'(MAX_RETRY);

    state_t      state, state_n;
    logic [3:0]  index, index_n;
    logic [1:0]  retry, retry_n;
    logic [10:0] cnt, cnt_n;
    logic [15:0] tmo, tmo_n;
    logic [3:0]  code, code_n;
    logic        busy_n, done_n, error_n;
    logic [3:0]  fidx_n, fcode_n;
    logic [6:0]  reg_q, reg_n;
    logic [8:0]  data_q, data_n;
    logic        rst_n_q;
    logic        auto_pend, auto_n;
    logic        go;

    logic        done_s1, done_s2, done_prev;
    logic [3:0]  err_s1, err_s2;
    logic        done_edge;

    logic [6:0]  rom_reg;
    logic [8:0]  rom_data;

    codec_cfg_rom #(.NUM_REGS(NUM_REGS)) u_rom (
        .idx      (index),
        .reg_addr (rom_reg),
        .reg_data (rom_data)
    );

    assign i2c.i2c_rst_n    = rst_n_q;
    assign i2c.i2c_address  = DEV_ADDR;
    assign i2c.i2c_register = reg_q;
    assign i2c.i2c_data     = data_q;
    assign i2c.i2c_rw       = 1'b0;

    // done_prev follows the synced level every cycle, so a done that is still
    // high from the previous transaction when WAIT is entered is not an edge.
    assign done_edge = done_s2 & ~done_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_s1   <= 1'b0;
            done_s2   <= 1'b0;
            done_prev <= 1'b0;
            err_s1    <= 4'h0;
            err_s2    <= 4'h0;
        end else begin
            done_s1   <= i2c.i2c_done;
            done_s2   <= done_s1;
            done_prev <= done_s2;
            err_s1    <= i2c.i2c_error;
            err_s2    <= err_s1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            index      <= '0;
            retry      <= '0;
            cnt        <= '0;
            tmo        <= '0;
            code       <= '0;
            busy       <= 1'b0;
            cfg_done   <= 1'b0;
            cfg_error  <= 1'b0;
            fail_index <= '0;
            fail_code  <= '0;
            reg_q      <= '0;
            data_q     <= '0;
            rst_n_q    <= 1'b0;
            auto_pend  <= AUTO_START;
        end else begin
            state      <= state_n;
            index      <= index_n;
            retry      <= retry_n;
            cnt        <= cnt_n;
            tmo        <= tmo_n;
            code       <= code_n;
            busy       <= busy_n;
            cfg_done   <= done_n;
            cfg_error  <= error_n;
            fail_index <= fidx_n;
            fail_code  <= fcode_n;
            reg_q      <= reg_n;
            data_q     <= data_n;
            // Registered so the controller enable is glitch-free; high only in WAIT.
            rst_n_q    <= (state_n == ST_WAIT);
            auto_pend  <= auto_n;
        end
    end

    always_comb begin
        state_n = state;
        index_n = index;
        retry_n = retry;
        cnt_n   = cnt;
        tmo_n   = tmo;
        code_n  = code;
        busy_n  = busy;
        done_n  = cfg_done;
        error_n = cfg_error;
        fidx_n  = fail_index;
        fcode_n = fail_code;
        reg_n   = reg_q;
        data_n  = data_q;
        auto_n  = auto_pend;
        go      = 1'b0;

        case (state)
            ST_IDLE: go = start | auto_pend;
            ST_DONE: go = start;
            ST_FAIL: go = start;
            ST_LOAD: begin
                reg_n   = rom_reg;
                data_n  = rom_data;
                cnt_n   = '0;
                state_n = ST_RST;
            end
            ST_RST: begin
                tmo_n = '0;
                if (cnt == HOLD_LAST) begin
                    state_n = ST_WAIT;
                end else begin
                    cnt_n = cnt + 11'd1;
                end
            end
            ST_WAIT: begin
                // A stale pass flag (F) is ignored; only the done edge means success.
                if (is_fail_code(err_s2)) begin
                    code_n  = err_s2;
                    state_n = ST_RETRY;
                end else if (done_edge) begin
                    cnt_n   = '0;
                    state_n = ST_GAP;
                end else if (tmo == TMO_LAST) begin
                    code_n  = ERR_TIMEOUT;
                    state_n = ST_RETRY;
                end else begin
                    tmo_n = tmo + 16'd1;
                end
            end
            ST_RETRY: begin
                if (retry < RETRY_MAX) begin
                    retry_n = retry + 2'd1;
                    state_n = ST_LOAD;
                end else begin
                    fidx_n  = index;
                    fcode_n = code;
                    busy_n  = 1'b0;
                    error_n = 1'b1;
                    state_n = ST_FAIL;
                end
            end
            ST_GAP: begin
                retry_n = '0;
                if (cnt == GAP_LAST) begin
                    cnt_n = '0;
                    if (index == LAST_IDX) begin
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = ST_DONE;
                    end else begin
                        index_n = index + 4'd1;
                        state_n = ST_LOAD;
                    end
                end else begin
                    cnt_n = cnt + 11'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Shared (re)start action from IDLE, DONE or FAIL; never taken while busy.
        if (go) begin
            auto_n  = 1'b0;
            done_n  = 1'b0;
            error_n = 1'b0;
            index_n = '0;
            retry_n = '0;
            busy_n  = 1'b1;
            state_n = ST_LOAD;
        end
    end

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// tb/tb_codec_cfg_sequencer.sv - testbench for codec_cfg_sequencer
module tb_codec_cfg_sequencer;

    localparam int NUM_REGS = 10;
    localparam int RST_HOLD = 4;
    localparam int GAP_CYC  = 8;
    localparam int TIMEOUT  = 200;
    localparam int LAT      = 10;

    localparam int K_OK    = 0;
    localparam int K_ERR   = 1;
    localparam int K_NONE  = 2;
    localparam int K_HOLD  = 3;
    localparam int K_ABORT = 4;

    typedef struct {
        logic [6:0] r;
        logic [8:0] d;
        int         kind;
        logic [3:0] code;
        bit         keep;
    } plan_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy, cfg_done, cfg_error;
    logic [3:0] fail_index, fail_code;

    int checks = 0;
    int errors = 0;

    plan_t plan_q[$];

    logic [6:0] exp_reg  [0:9] = '{7'h0F, 7'h06, 7'h02, 7'h03, 7'h04,
                                   7'h05, 7'h07, 7'h08, 7'h00, 7'h09};
    logic [8:0] exp_data [0:9] = '{9'h000, 9'h002, 9'h079, 9'h079, 9'h012,
                                   9'h006, 9'h042, 9'h000, 9'h017, 9'h001};

    codec_cfg_sequencer_if i2c ();

    codec_cfg_sequencer #(
        .NUM_REGS       (NUM_REGS),
        .DEV_ADDR       (7'h1A),
        .RST_HOLD       (RST_HOLD),
        .GAP_CYCLES     (GAP_CYC),
        .TIMEOUT_CYCLES (TIMEOUT),
        .MAX_RETRY      (3),
        .AUTO_START     (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .i2c        (i2c),
        .busy       (busy),
        .cfg_done   (cfg_done),
        .cfg_error  (cfg_error),
        .fail_index (fail_index),
        .fail_code  (fail_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int idx, input int kind, input logic [3:0] code, input bit keep);
        plan_t p;
        p.r    = exp_reg[idx];
        p.d    = exp_data[idx];
        p.kind = kind;
        p.code = code;
        p.keep = keep;
        plan_q.push_back(p);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cfg_done || cfg_error) begin
                seen = 1'b1;
                break;
            end
        end
        check("sequence_end_reached", 32'(seen), 32'd1);
    endtask

    // Controller model: pops one planned attempt per enable rise, checks the
    // presented entry, responds after LAT cycles and judges the attempt length.
    initial begin
        plan_t cur;
        int    hi_cnt  = 0;
        int    resp_at = 0;
        bit    prev_en = 1'b0;
        cur = '{7'h0, 9'h0, K_ABORT, 4'h0, 1'b0};
        i2c.i2c_done  = 1'b0;
        i2c.i2c_error = 4'h0;
        forever begin
            @(negedge clk);
            if (i2c.i2c_rst_n === 1'b1) begin
                if (!prev_en) begin
                    hi_cnt  = 1;
                    resp_at = 0;
                    check("txn_expected", 32'(plan_q.size() != 0), 32'd1);
                    if (plan_q.size() != 0) cur = plan_q.pop_front();
                    else cur = '{7'h0, 9'h0, K_ABORT, 4'h0, 1'b0};
                    check("txn_register", 32'(i2c.i2c_register), 32'(cur.r));
                    check("txn_data", 32'(i2c.i2c_data), 32'(cur.d));
                    check("txn_address", 32'(i2c.i2c_address), 32'h1A);
                    check("txn_rw", 32'(i2c.i2c_rw), 32'd0);
                end else begin
                    hi_cnt++;
                end
                if (hi_cnt == LAT) begin
                    case (cur.kind)
                        K_OK:  begin i2c.i2c_done = 1'b1; i2c.i2c_error = 4'hF; resp_at = hi_cnt; end
                        K_ERR: begin i2c.i2c_error = cur.code; resp_at = hi_cnt; end
                        K_HOLD: i2c.i2c_done = 1'b0;
                        default: ;
                    endcase
                end
                if (hi_cnt == 2 * LAT && cur.kind == K_HOLD) begin
                    i2c.i2c_done  = 1'b1;
                    i2c.i2c_error = 4'hF;
                    resp_at = hi_cnt;
                end
            end else begin
                if (prev_en) begin
                    if (cur.kind == K_NONE)
                        check("timeout_length", 32'(hi_cnt), 32'(TIMEOUT));
                    else if (cur.kind != K_ABORT)
                        check("response_latency",
                              32'(resp_at != 0 && hi_cnt > resp_at && hi_cnt <= resp_at + 4), 32'd1);
                end
                if (!cur.keep) begin
                    i2c.i2c_done  = 1'b0;
                    i2c.i2c_error = 4'h0;
                end
            end
            prev_en = (i2c.i2c_rst_n === 1'b1);
        end
    end

    initial begin
        bit seen;
        rst   = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);

        check("reset_i2c_rst_n", 32'(i2c.i2c_rst_n), 32'd0);
        check("reset_register", 32'(i2c.i2c_register), 32'd0);
        check("reset_data", 32'(i2c.i2c_data), 32'd0);
        check("reset_rw", 32'(i2c.i2c_rw), 32'd0);
        check("reset_address", 32'(i2c.i2c_address), 32'h1A);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_cfg_done", 32'(cfg_done), 32'd0);
        check("reset_cfg_error", 32'(cfg_error), 32'd0);
        check("reset_fail_index", 32'(fail_index), 32'd0);
        check("reset_fail_code", 32'(fail_code), 32'd0);

        // Auto start, every entry succeeds
        for (int i = 0; i < NUM_REGS; i++) push(i, K_OK, 4'h0, 1'b0);
        rst = 1'b1;
        wait_end(2000);
        check("s1_cfg_done", 32'(cfg_done), 32'd1);
        check("s1_cfg_error", 32'(cfg_error), 32'd0);
        check("s1_busy", 32'(busy), 32'd0);
        check("s1_i2c_rst_n", 32'(i2c.i2c_rst_n), 32'd0);
        check("s1_plan_consumed", 32'(plan_q.size()), 32'd0);

        // Error 2 on entry 3 first attempt only: resent once
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i == 3) push(i, K_ERR, 4'h2, 1'b0);
            push(i, K_OK, 4'h0, 1'b0);
        end
        pulse_start();
        wait_end(2000);
        check("s2_cfg_done", 32'(cfg_done), 32'd1);
        check("s2_cfg_error", 32'(cfg_error), 32'd0);
        check("s2_plan_consumed", 32'(plan_q.size()), 32'd0);

        // Error 3 on entry 5 every attempt: four attempts then abort
        for (int i = 0; i < 5; i++) push(i, K_OK, 4'h0, 1'b0);
        for (int a = 0; a < 4; a++) push(5, K_ERR, 4'h3, 1'b0);
        pulse_start();
        wait_end(2000);
        repeat (50) @(negedge clk);
        check("s3_cfg_error", 32'(cfg_error), 32'd1);
        check("s3_cfg_done", 32'(cfg_done), 32'd0);
        check("s3_busy", 32'(busy), 32'd0);
        check("s3_fail_index", 32'(fail_index), 32'd5);
        check("s3_fail_code", 32'(fail_code), 32'h3);
        check("s3_i2c_rst_n", 32'(i2c.i2c_rst_n), 32'd0);
        check("s3_plan_consumed", 32'(plan_q.size()), 32'd0);

        // Controller never answers on entry 0: four timeouts then abort
        for (int a = 0; a < 4; a++) push(0, K_NONE, 4'h0, 1'b0);
        pulse_start();
        wait_end(3000);
        check("s4_cfg_error", 32'(cfg_error), 32'd1);
        check("s4_fail_index", 32'(fail_index), 32'd0);
        check("s4_fail_code", 32'(fail_code), 32'hE);
        check("s4_plan_consumed", 32'(plan_q.size()), 32'd0);

        // Done held high from entry 0 into entry 1: must wait for fall then rise
        push(0, K_OK, 4'h0, 1'b1);
        push(1, K_HOLD, 4'h0, 1'b0);
        for (int i = 2; i < NUM_REGS; i++) push(i, K_OK, 4'h0, 1'b0);
        pulse_start();
        wait_end(2000);
        check("s5_cfg_done", 32'(cfg_done), 32'd1);
        check("s5_cfg_error", 32'(cfg_error), 32'd0);
        check("s5_plan_consumed", 32'(plan_q.size()), 32'd0);

        // Reset in the middle of entry 4, then start while busy is ignored
        for (int i = 0; i < 4; i++) push(i, K_OK, 4'h0, 1'b0);
        push(4, K_ABORT, 4'h0, 1'b0);
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (i2c.i2c_rst_n === 1'b1 && i2c.i2c_register === 7'h04) begin
                seen = 1'b1;
                break;
            end
        end
        check("s6_entry4_reached", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("s6_async_i2c_rst_n", 32'(i2c.i2c_rst_n), 32'd0);
        check("s6_async_busy", 32'(busy), 32'd0);
        check("s6_plan_consumed", 32'(plan_q.size()), 32'd0);
        for (int i = 0; i < NUM_REGS; i++) push(i, K_OK, 4'h0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("s6_busy_after_rerun", 32'(busy), 32'd1);
        pulse_start();
        wait_end(2000);
        repeat (20) @(negedge clk);
        check("s6_cfg_done", 32'(cfg_done), 32'd1);
        check("s6_cfg_error", 32'(cfg_error), 32'd0);
        check("s6_plan_consumed_rerun", 32'(plan_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
